// File: rtl/sisc_mem_arb.sv
// Round-robin arbiter sharing one single-ported memory between the fetch (IF)
// and load/store (LS) paths, with a fixed number of memory wait states.
//
// state  | meaning
// IDLE   | sample requests, grant one, latch its command
// ACCESS | drive memory from latched command for WAIT+1 cycles
// DONE   | one-cycle ack to the granted port
module sisc_mem_arb #(
   parameter int AW   = 16,
   parameter int DW   = 32,
   parameter int WAIT = 1
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic [DW-1:0] ls_rdata,
   output logic          ls_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_LS = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            last_gnt;
   logic            sel_q;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [2:0]      cnt_q;
   logic            gnt_valid;
   logic            gnt_sel;
   logic            last_access;

   // Contention goes to whichever port was not served last.
   always_comb begin
      gnt_valid = if_req | ls_req;
      gnt_sel   = GNT_IF;
      if (if_req && ls_req)
         gnt_sel = (last_gnt == GNT_LS) ? GNT_IF : GNT_LS;
      else if (ls_req)
         gnt_sel = GNT_LS;
   end

   assign last_access = (state == ACCESS) && (cnt_q == 3'd0);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_valid) state_nxt = ACCESS;
         ACCESS:  if (last_access) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         last_gnt <= GNT_LS;
         sel_q    <= GNT_IF;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= 3'd0;
         if_rdata <= '0;
         ls_rdata <= '0;
      end else begin
         if (state == IDLE && gnt_valid) begin
            last_gnt <= gnt_sel;
            sel_q    <= gnt_sel;
            cnt_q    <= 3'(WAIT);
            if (gnt_sel == GNT_LS) begin
               we_q    <= ls_we;
               addr_q  <= ls_addr;
               wdata_q <= ls_wdata;
            end else begin
               we_q    <= 1'b0;
               addr_q  <= if_addr;
               wdata_q <= '0;
            end
         end else if (state == ACCESS) begin
            if (cnt_q != 3'd0) begin
               cnt_q <= cnt_q - 3'd1;
            end else if (sel_q == GNT_IF) begin
               if_rdata <= mem_rdata;
            end else if (!we_q) begin
               ls_rdata <= mem_rdata;
            end
         end
      end
   end

   assign mem_en    = (state == ACCESS);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = mem_en ? addr_q : '0;
   assign mem_wdata = mem_en ? wdata_q : '0;
   assign if_ack    = (state == DONE) && (sel_q == GNT_IF);
   assign ls_ack    = (state == DONE) && (sel_q == GNT_LS);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Directed bench for sisc_mem_arb: WAIT=1 instance for the main sequence and
// a WAIT=0 instance for the zero-wait-state read.
module tb_sisc_mem_arb;

   logic        clk = 1'b0;
   logic        rst_f = 1'b0;
   int          checks = 0;
   int          errors = 0;

   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [15:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic [31:0] ls_rdata;
   logic        ls_ack;
   logic        mem_en, mem_we, busy;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic        if0_req = 1'b0;
   logic [15:0] if0_addr = '0;
   logic [31:0] if0_rdata;
   logic        if0_ack;
   logic        ls0_req = 1'b0;
   logic        ls0_we = 1'b0;
   logic [15:0] ls0_addr = '0;
   logic [31:0] ls0_wdata = '0;
   logic [31:0] ls0_rdata;
   logic        ls0_ack;
   logic        mem0_en, mem0_we, busy0;
   logic [15:0] mem0_addr;
   logic [31:0] mem0_wdata, mem0_rdata;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return (a == 16'h0010) ? 32'h1234ABCD : {16'hA5A5, a};
   endfunction

   assign mem_rdata  = mem_word(mem_addr);
   assign mem0_rdata = mem_word(mem0_addr);

   always #5 clk = ~clk;

   sisc_mem_arb #(.AW(16), .DW(32), .WAIT(1)) dut (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rdata(ls_rdata), .ls_ack(ls_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   sisc_mem_arb #(.AW(16), .DW(32), .WAIT(0)) dut0 (
      .clk(clk), .rst_f(rst_f),
      .if_req(if0_req), .if_addr(if0_addr), .if_rdata(if0_rdata), .if_ack(if0_ack),
      .ls_req(ls0_req), .ls_we(ls0_we), .ls_addr(ls0_addr), .ls_wdata(ls0_wdata),
      .ls_rdata(ls0_rdata), .ls_ack(ls0_ack),
      .mem_en(mem0_en), .mem_we(mem0_we), .mem_addr(mem0_addr),
      .mem_wdata(mem0_wdata), .mem_rdata(mem0_rdata), .busy(busy0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_f) check("acks_exclusive", 32'(if_ack & ls_ack), 32'd0);
   end

   initial begin
      // reset state
      tick();
      tick();
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_ls_rdata", ls_rdata, 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_acks", {30'd0, if_ack, ls_ack}, 0);
      rst_f = 1'b1;

      // IF read, WAIT=1
      if_addr = 16'h0010;
      if_req  = 1'b1;
      tick();
      check("if_acc1_en", 32'(mem_en), 1);
      check("if_acc1_addr", 32'(mem_addr), 32'h0010);
      check("if_acc1_we", 32'(mem_we), 0);
      check("if_acc1_busy", 32'(busy), 1);
      tick();
      check("if_acc2_en", 32'(mem_en), 1);
      check("if_acc2_ack", 32'(if_ack), 0);
      tick();
      check("if_done_en", 32'(mem_en), 0);
      check("if_done_ack", 32'(if_ack), 1);
      check("if_rdata", if_rdata, 32'h1234ABCD);
      if_req = 1'b0;
      tick();
      check("if_idle_ack", 32'(if_ack), 0);
      check("if_idle_busy", 32'(busy), 0);

      // LS load at 0x0030
      ls_addr = 16'h0030;
      ls_we   = 1'b0;
      ls_req  = 1'b1;
      tick();
      check("ld_addr", 32'(mem_addr), 32'h0030);
      tick();
      tick();
      check("ld_ack", 32'(ls_ack), 1);
      check("ld_rdata", ls_rdata, 32'hA5A50030);
      ls_req = 1'b0;
      tick();

      // LS store, address changed mid-access
      ls_addr  = 16'h0020;
      ls_wdata = 32'hDEADBEEF;
      ls_we    = 1'b1;
      ls_req   = 1'b1;
      tick();
      check("st1_we", 32'(mem_we), 1);
      check("st1_wdata", mem_wdata, 32'hDEADBEEF);
      check("st1_addr", 32'(mem_addr), 32'h0020);
      ls_addr = 16'h0030;
      tick();
      check("st2_we", 32'(mem_we), 1);
      check("st2_wdata", mem_wdata, 32'hDEADBEEF);
      check("st2_addr_held", 32'(mem_addr), 32'h0020);
      tick();
      check("st_ack", 32'(ls_ack), 1);
      check("st_en_off", 32'(mem_en), 0);
      check("st_rdata_kept", ls_rdata, 32'hA5A50030);
      ls_req = 1'b0;
      ls_we  = 1'b0;
      tick();
      check("st_ack_once", 32'(ls_ack), 0);

      // continuous contention from reset
      rst_f = 1'b0;
      tick();
      rst_f   = 1'b1;
      if_addr = 16'h0040;
      ls_addr = 16'h0050;
      if_req  = 1'b1;
      ls_req  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_addr", 32'(mem_addr), (i % 2 == 0) ? 32'h0040 : 32'h0050);
         tick();
         tick();
         check("rr_if_ack", 32'(if_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_ls_ack", 32'(ls_ack), (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i % 2 == 0) check("rr_if_rdata", if_rdata, 32'hA5A50040);
         else            check("rr_ls_rdata", ls_rdata, 32'hA5A50050);
         tick();
      end

      // reset in the second ACCESS cycle of an IF fetch (last_gnt=IF before reset)
      ls_req = 1'b0;
      tick();
      check("pre_rst_addr", 32'(mem_addr), 32'h0040);
      tick();
      check("pre_rst_en", 32'(mem_en), 1);
      rst_f = 1'b0;
      #1;
      check("rst_mid_en", 32'(mem_en), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_ack", {30'd0, if_ack, ls_ack}, 0);
      tick();
      check("rst_mid_noack", {30'd0, if_ack, ls_ack}, 0);
      check("rst_mid_rdata", if_rdata, 0);
      ls_req = 1'b1;
      rst_f  = 1'b1;
      tick();
      check("post_rst_if_first", 32'(mem_addr), 32'h0040);
      check("post_rst_we", 32'(mem_we), 0);
      tick();
      tick();
      check("post_rst_if_ack", {30'd0, if_ack, ls_ack}, 32'd2);
      if_req = 1'b0;
      tick();
      tick();
      check("post_rst_ls_addr", 32'(mem_addr), 32'h0050);
      tick();
      tick();
      check("post_rst_ls_ack", {30'd0, if_ack, ls_ack}, 32'd1);
      check("post_rst_ls_rdata", ls_rdata, 32'hA5A50050);
      ls_req = 1'b0;
      tick();

      // WAIT=0 instance, single IF read
      if0_addr = 16'h0010;
      if0_req  = 1'b1;
      tick();
      check("w0_en", 32'(mem0_en), 1);
      check("w0_addr", 32'(mem0_addr), 32'h0010);
      check("w0_no_ack", 32'(if0_ack), 0);
      tick();
      check("w0_en_off", 32'(mem0_en), 0);
      check("w0_ack", 32'(if0_ack), 1);
      check("w0_rdata", if0_rdata, 32'h1234ABCD);
      if0_req = 1'b0;
      tick();
      check("w0_idle", {30'd0, if0_ack, busy0}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sisc_mem_arb.md
Name: sisc_mem_arb

Overview:
- Sequential arbiter that shares one single-ported SISC memory between two requesters: the instruction-fetch path (IF, read-only) and the load/store path (LS, read/write).
- Sits between the processor control/datapath and memory. It latches the granted request, drives the memory for a fixed number of wait states, captures read data, and returns a one-cycle acknowledge.
- Arbitration is round-robin when both requesters are active.

Parameters:
- AW, 16, address width (matches 16-bit PC/branch address).
- DW, 32, data width (matches register file and instruction width).
- WAIT, 1, extra memory wait cycles; legal range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_f  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_rdata  out  DW  fetched word; valid with if_ack, held until the next IF completion.
- if_ack  out  1  one-cycle completion pulse for IF.
- ls_req  in  1  load/store request; held high until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  DW  store data.
- ls_rdata  out  DW  load data; valid with ls_ack, held until the next LS load completion.
- ls_ack  out  1  one-cycle completion pulse for LS.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in the last ACCESS cycle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_f=0):
  - state=IDLE, last_gnt=LS, wait counter=0.
  - All outputs 0, including if_rdata and ls_rdata.
  - An in-flight access is abandoned immediately; no ack is issued for it.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - At each rising edge, sample if_req and ls_req.
  - Only one requester active: grant it.
  - Both active: grant the port that is not last_gnt. Set last_gnt to the granted port.
  - On grant, latch sel, addr, we and wdata into internal registers, load counter=WAIT, and go to ACCESS.
  - IF grants always latch we=0.
  - No request: stay in IDLE.
- ACCESS:
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the latched registers only. Requester input changes have no effect.
  - Counter nonzero: decrement it and stay in ACCESS.
  - Counter zero: this is the last ACCESS cycle. At the edge, capture mem_rdata into the granted port's rdata register (loads and fetches only; stores leave ls_rdata unchanged), then go to DONE.
  - mem_en is high for exactly WAIT+1 cycles.
- DONE:
  - The granted port's ack=1 for exactly one cycle; mem_en=0.
  - Always returns to IDLE.
- Latency: request sampled at edge N gives ACCESS cycles N+1..N+WAIT+1, ack in cycle N+WAIT+2, and the earliest next grant at the edge ending the IDLE cycle N+WAIT+3.
- Throughput:
  - Minimum WAIT+3 cycles per access.
  - A requester still holding req in the IDLE cycle after its ack issues a new request; requesters must drop req in the cycle following ack.
- if_ack and ls_ack are never high in the same cycle.
- Protocol violation: if req drops during ACCESS, the access completes and ack still pulses.
- Simultaneous requests: round-robin guarantees no starvation. Under continuous contention, grants alternate IF, LS, IF, LS.
- last_gnt updates only on a grant; idle cycles do not change it.

Test Plan:
- Reset, WAIT=1, then IF only with if_addr=0x0010 and memory returning 0x1234ABCD:
  - mem_en=1 for 2 cycles with mem_addr=0x0010 and mem_we=0.
  - if_ack pulses 3 cycles after the sampling edge; if_rdata=0x1234ABCD.
- LS store with ls_addr=0x0020 and ls_wdata=0xDEADBEEF:
  - mem_we=1 and mem_wdata=0xDEADBEEF for 2 cycles.
  - ls_ack pulses once; ls_rdata keeps its prior value.
- if_req and ls_req both held continuously from reset:
  - Grant order is IF, LS, IF, LS; acks are never coincident.
  - ls_rdata and if_rdata each carry the word from their own address.
- Change ls_addr from 0x0020 to 0x0030 in the middle of ACCESS:
  - mem_addr stays 0x0020 for the whole access.
- Drive rst_f=0 in the second ACCESS cycle:
  - Immediately mem_en=0, busy=0, no ack.
  - After release, a pending IF wins first (last_gnt=LS).
- WAIT=0 build, single IF read:
  - mem_en is high for exactly 1 cycle; if_ack arrives 2 cycles after the sampling edge.
